// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register widths and write-back source encoding.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Handshake bundle between the two write-back requesters and the arbiter.
interface wb_port_arbiter_if;

  logic alu_valid;
  logic alu_ready;
  logic mem_valid;
  logic mem_ready;
  logic hold;

  modport master (
    output alu_valid,
    output mem_valid,
    output hold,
    input  alu_ready,
    input  mem_ready
  );

  modport slave (
    input  alu_valid,
    input  mem_valid,
    input  hold,
    output alu_ready,
    output mem_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter with hold; grants are combinational, pointer registered.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   hs
);

  wb_src_e r_ptr;

  always_comb begin
    hs.alu_ready = 1'b0;
    hs.mem_ready = 1'b0;
    if (!hs.hold) begin
      if (hs.alu_valid && hs.mem_valid) begin
        hs.alu_ready = (r_ptr == SRC_ALU);
        hs.mem_ready = (r_ptr == SRC_MEM);
      end else begin
        hs.alu_ready = hs.alu_valid;
        hs.mem_ready = hs.mem_valid;
      end
    end
  end

  // Pointer moves to the loser of each transfer so a steady pair alternates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SRC_ALU;
    end else if (hs.alu_valid && hs.alu_ready) begin
      r_ptr <= SRC_MEM;
    end else if (hs.mem_valid && hs.mem_ready) begin
      r_ptr <= SRC_ALU;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-back port shared by the ALU and load pipes, one-cycle registered output.
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic              alu_we,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_we,
  input  logic              hold,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] reg_addr_out,
  output logic              write_enable_out,
  output logic              wb_src,
  output logic              collision
);

  wb_port_arbiter_if w_hs ();

  logic              w_alu_xfer;
  logic              w_mem_xfer;
  logic              w_race;

  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  wb_src_e           r_src;
  logic              r_coll;

  assign w_hs.alu_valid = alu_valid;
  assign w_hs.mem_valid = mem_valid;
  assign w_hs.hold      = hold;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .hs    (w_hs.slave)
  );

  assign alu_ready  = w_hs.alu_ready;
  assign mem_ready  = w_hs.mem_ready;
  assign w_alu_xfer = alu_valid & w_hs.alu_ready;
  assign w_mem_xfer = mem_valid & w_hs.mem_ready;
  assign w_race     = alu_valid & mem_valid & alu_we & mem_we & ~hold
                    & (alu_addr == mem_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
      r_src  <= SRC_ALU;
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_race;
      if (w_alu_xfer) begin
        r_data <= alu_data;
        r_addr <= alu_addr;
        r_we   <= alu_we;
        r_src  <= SRC_ALU;
      end else if (w_mem_xfer) begin
        r_data <= mem_data;
        r_addr <= mem_addr;
        r_we   <= mem_we;
        r_src  <= SRC_MEM;
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

  assign write_data       = r_data;
  assign reg_addr_out     = r_addr;
  assign write_enable_out = r_we;
  assign wb_src           = r_src;
  assign collision        = r_coll;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed checks of wb_port_arbiter against a behavioural write-back model.
module tb_wb_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] alu_data, mem_data;
  logic [AW-1:0] alu_addr, mem_addr;
  logic          alu_we, mem_we;
  logic [DW-1:0] write_data;
  logic [AW-1:0] reg_addr_out;
  logic          write_enable_out, wb_src, collision;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_valid        (bus.alu_valid),
    .alu_ready        (bus.alu_ready),
    .alu_data         (alu_data),
    .alu_addr         (alu_addr),
    .alu_we           (alu_we),
    .mem_valid        (bus.mem_valid),
    .mem_ready        (bus.mem_ready),
    .mem_data         (mem_data),
    .mem_addr         (mem_addr),
    .mem_we           (mem_we),
    .hold             (bus.hold),
    .write_data       (write_data),
    .reg_addr_out     (reg_addr_out),
    .write_enable_out (write_enable_out),
    .wb_src           (wb_src),
    .collision        (collision)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: -1 none, 0 ALU, 1 MEM.
  function automatic int grant_of(input logic av, input logic mv, input logic h, input int ptr);
    if (h)        return -1;
    if (av && mv) return ptr;
    if (av)       return 0;
    if (mv)       return 1;
    return -1;
  endfunction

  int            m_ptr      = 0;
  int            m_last_gnt = -1;
  logic [DW-1:0] m_data     = '0;
  logic [AW-1:0] m_addr     = '0;
  logic          m_we       = 1'b0;
  logic          m_src      = 1'b0;
  logic          m_coll     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_ptr = 0; m_last_gnt = -1; m_data = '0; m_addr = '0;
      m_we = 1'b0; m_src = 1'b0; m_coll = 1'b0;
    end else begin
      g = grant_of(bus.alu_valid, bus.mem_valid, bus.hold, m_ptr);
      m_coll = bus.alu_valid && bus.mem_valid && alu_we && mem_we &&
               (alu_addr == mem_addr) && !bus.hold;
      if (g == 0) begin
        m_data = alu_data; m_addr = alu_addr; m_we = alu_we; m_src = 1'b0; m_ptr = 1;
      end else if (g == 1) begin
        m_data = mem_data; m_addr = mem_addr; m_we = mem_we; m_src = 1'b1; m_ptr = 0;
      end else begin
        m_we = 1'b0;
      end
      m_last_gnt = g;
    end
  end

  always @(negedge clk) begin
    int g;
    g = grant_of(bus.alu_valid, bus.mem_valid, bus.hold, m_ptr);
    chk("alu_ready",        {31'd0, bus.alu_ready},      {31'd0, g == 0});
    chk("mem_ready",        {31'd0, bus.mem_ready},      {31'd0, g == 1});
    chk("write_enable_out", {31'd0, write_enable_out},   {31'd0, m_we});
    chk("write_data",       {16'd0, write_data},         {16'd0, m_data});
    chk("reg_addr_out",     {28'd0, reg_addr_out},       {28'd0, m_addr});
    chk("wb_src",           {31'd0, wb_src},             {31'd0, m_src});
    chk("collision",        {31'd0, collision},          {31'd0, m_coll});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic av, input logic [DW-1:0] ad, input logic [AW-1:0] aa, input logic aw,
                     input logic mv, input logic [DW-1:0] md, input logic [AW-1:0] ma, input logic mw,
                     input logic h);
    bus.alu_valid = av; alu_data = ad; alu_addr = aa; alu_we = aw;
    bus.mem_valid = mv; mem_data = md; mem_addr = ma; mem_we = mw;
    bus.hold = h;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [AW-1:0] a,
                         input logic src, input logic col);
    chk({tag, "_we"},   {31'd0, write_enable_out}, {31'd0, we});
    chk({tag, "_addr"}, {28'd0, reg_addr_out},     {28'd0, a});
    chk({tag, "_src"},  {31'd0, wb_src},           {31'd0, src});
    chk({tag, "_col"},  {31'd0, collision},        {31'd0, col});
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);
    step();
    chk("reset_we",   {31'd0, write_enable_out}, 32'd0);
    chk("reset_data", {16'd0, write_data},       32'd0);
    do_reset();

    // ALU only
    drv(1, 16'h1234, 4'd3, 1, 0, 16'h0, 4'd0, 0, 0);
    chk("d1_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    step();
    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);
    chk_out("d1", 1'b1, 4'd3, 1'b0, 1'b0);
    chk("d1_data", {16'd0, write_data}, 32'h1234);

    // Both valid: strict alternation starting at ALU
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1, 16'(16'hA000 + i), 4'd1, 1, 1, 16'(16'hB000 + i), 4'd2, 1, 0);
      chk("d2_alu_ready", {31'd0, bus.alu_ready}, {31'd0, (i % 2) == 0});
      step();
      chk_out("d2", 1'b1, (i % 2 == 0) ? 4'd1 : 4'd2, 1'((i % 2) == 1), 1'b0);
    end
    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);

    // Hold stalls both sources, pointer unchanged
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 16'h1111, 4'd8, 1, 1, 16'h2222, 4'd9, 1, 1);
      chk("d3_ready_any", {30'd0, bus.alu_ready, bus.mem_ready}, 32'd0);
      step();
      chk("d3_we", {31'd0, write_enable_out}, 32'd0);
    end
    drv(1, 16'h1111, 4'd8, 1, 1, 16'h2222, 4'd9, 1, 0);
    chk("d3_alu_first", {31'd0, bus.alu_ready}, 32'd1);
    step();
    chk_out("d3", 1'b1, 4'd8, 1'b0, 1'b0);
    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);

    // Same-register race
    do_reset();
    drv(1, 16'h0AAA, 4'd5, 1, 1, 16'h0BBB, 4'd5, 1, 0);
    step();
    chk_out("d4a", 1'b1, 4'd5, 1'b0, 1'b1);
    drv(0, '0, '0, 0, 1, 16'h0BBB, 4'd5, 1, 0);
    chk("d4_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    step();
    chk_out("d4b", 1'b1, 4'd5, 1'b1, 1'b0);
    chk("d4_data", {16'd0, write_data}, 32'h0BBB);

    // Load with no write retires without a strobe
    drv(0, '0, '0, 0, 1, 16'h7777, 4'd7, 0, 0);
    chk("d5_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    step();
    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);
    chk_out("d5", 1'b0, 4'd7, 1'b1, 1'b0);

    // Reset right after a transfer
    drv(1, 16'hBEEF, 4'd0, 1, 0, '0, '0, 0, 0);
    step();
    chk("d6_pre_we", {31'd0, write_enable_out}, 32'd1);
    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_out("d6_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("d6_rst_data", {16'd0, write_data}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("d6_post_we", {31'd0, write_enable_out}, 32'd0);

    // Randomized traffic; pending requests stay stable until granted
    for (int n = 0; n < 3000; n++) begin
      logic av, aw, mv, mw, h;
      logic [DW-1:0] ad, md;
      logic [AW-1:0] aa, ma;
      if (bus.alu_valid && m_last_gnt != 0) begin
        av = 1; ad = alu_data; aa = alu_addr; aw = alu_we;
      end else begin
        av = ($urandom_range(0, 9) < 6); ad = DW'($urandom); aa = AW'($urandom_range(0, 3));
        aw = ($urandom_range(0, 3) != 0);
      end
      if (bus.mem_valid && m_last_gnt != 1) begin
        mv = 1; md = mem_data; ma = mem_addr; mw = mem_we;
      end else begin
        mv = ($urandom_range(0, 9) < 6); md = DW'($urandom); ma = AW'($urandom_range(0, 3));
        mw = ($urandom_range(0, 3) != 0);
      end
      h = ($urandom_range(0, 3) == 0);
      drv(av, ad, aa, aw, mv, md, ma, mw, h);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    drv(0, '0, '0, 0, 0, '0, '0, 0, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register address width.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low; ports SHALL be named clk and rst_n.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- alu_valid  in  1  ALU pipe has a result
- alu_ready  out  1  ALU result accepted this cycle
- alu_data  in  DATA_W  ALU result
- alu_addr  in  ADDR_W  ALU destination register
- alu_we  in  1  ALU result writes the register file
- mem_valid  in  1  load pipe has a result
- mem_ready  out  1  load result accepted this cycle
- mem_data  in  DATA_W  load result
- mem_addr  in  ADDR_W  load destination register
- mem_we  in  1  load result writes the register file
- hold  in  1  register file write port unavailable
- write_data  out  DATA_W  register file write data
- reg_addr_out  out  ADDR_W  register file write address
- write_enable_out  out  1  register file write strobe
- wb_src  out  1  source of current output: 0 = ALU, 1 = MEM
- collision  out  1  same-register write race detected

Function
REQ-005 A transfer on a source SHALL occur when its valid and ready are both high at a rising clk edge.
REQ-006 alu_ready and mem_ready SHALL be combinational from the valids, hold and the priority pointer; at most one SHALL be high in any cycle.
REQ-007 When hold is high, both readys SHALL be low and the priority pointer SHALL be unchanged.
REQ-008 With only one source valid and hold low, that source SHALL be granted regardless of the pointer.
REQ-009 With both sources valid and hold low, the source named by the priority pointer SHALL be granted.
REQ-010 After each transfer, the pointer SHALL name the non-granted source; with no transfer, it SHALL hold.
REQ-011 Output latency SHALL be exactly 1 cycle: on the edge after a transfer, write_data, reg_addr_out and wb_src SHALL take the granted source's values, and write_enable_out SHALL equal that source's we.
REQ-012 write_enable_out SHALL be a 1-cycle pulse and SHALL be low in every cycle not preceded by a transfer.
REQ-013 write_data, reg_addr_out and wb_src SHALL hold their last values when no transfer occurs.
REQ-014 A transfer with we low SHALL retire the request without a write: write_enable_out SHALL be low, other outputs SHALL still update.
REQ-015 collision SHALL pulse high for 1 cycle, aligned with write_enable_out, when in the prior cycle both valids and both wes were high, alu_addr equalled mem_addr, and hold was low.
REQ-016 Requesters SHALL keep valid, data, addr and we stable until their transfer; the block SHALL NOT check this.
REQ-017 Address 0 SHALL be treated as an ordinary register, with no special casing.

Reset
REQ-018 While rst_n is low: write_data = 0, reg_addr_out = 0, write_enable_out = 0, wb_src = 0, collision = 0, and the pointer SHALL name ALU.
REQ-019 Reset asserted mid-operation SHALL discard any pending grant; no write_enable_out pulse SHALL follow reset release without a new transfer.

Structure
REQ-020 DATA_W/ADDR_W defaults and the source encoding (SRC_ALU = 0, SRC_MEM = 1) SHALL live in shared package cpu_pkg.
REQ-021 Grant and pointer logic SHALL be a sub-module rr_arb2 (2 requests, hold, 2 one-hot grants, registered pointer); output registers stay in wb_port_arbiter.

Verification
REQ-022 ALU only: alu_valid = 1, alu_addr = 3, alu_data = 0x1234, alu_we = 1 -> alu_ready = 1 same cycle; next cycle write_enable_out = 1, reg_addr_out = 3, write_data = 0x1234, wb_src = 0.
REQ-023 Both valid for 4 cycles after reset -> grants ALU, MEM, ALU, MEM; wb_src sequence 0, 1, 0, 1.
REQ-024 Both valid, hold = 1 for 3 cycles, then 0 -> no readys and write_enable_out = 0 for those 3 cycles, then ALU is granted first.
REQ-025 Both valid, we = 1, both addr = 5 -> collision = 1 with the ALU write; next cycle MEM write to 5, collision = 0.
REQ-026 mem_valid = 1, mem_we = 0, mem_addr = 7 -> mem_ready = 1; next cycle write_enable_out = 0, reg_addr_out = 7, wb_src = 1.
REQ-027 rst_n pulled low in the cycle after a transfer -> all outputs 0 immediately; no write pulse after release.
